sram_frame_writer: RTL and testbench

- Write-side counterpart of the SRAM-backed VGA display path.
- Accepts a raster-ordered RGB888 pixel stream (valid/ready) and converts each pixel to RGB565: red in bits [15:11], green in [10:5], blue in [4:0].
- Writes each pixel into the async SRAM frame buffer at linear address y*H_DISPLAY + x, the same layout the display path reads.
- Generates SRAM control strobes with explicit setup, write-pulse and hold phases.

---
 rtl/vga_fb_pkg.sv | 46 ++++
 rtl/rgb888_to_rgb565.sv | 53 +++++
 rtl/sram_frame_writer.sv | 184 ++++++++++++++++++
 tb/tb_sram_frame_writer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared definitions for the SRAM frame-buffer write path and display path:
// writer FSM states, RGB565 field positions, default raster size and rounding helpers.
package vga_fb_pkg;

    // CONV is visited only when SRAM_FRAME_WRITER_ROUND_EN adds the rounding register stage.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WRITE = 3'd2,
        HOLD  = 3'd3,
        CONV  = 3'd4
    } fb_wr_state_t;

    localparam int DEFAULT_H_DISPLAY = 640;
    localparam int DEFAULT_V_DISPLAY = 480;

    localparam int RGB565_R_MSB = 15;
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_G_MSB = 10;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_B_MSB = 4;
    localparam int RGB565_B_LSB = 0;

    // (c + 4) >> 3, clamped to 31; the carry out of bit 7 is the only overflow case
    function automatic logic [4:0] round_to_5(input logic [7:0] c);
        logic [8:0] sum;
        sum = {1'b0, c} + 9'd4;
        if (sum[8]) begin
            return 5'd31;
        end else begin
            return sum[7:3];
        end
    endfunction

    // (c + 2) >> 2, clamped to 63
    function automatic logic [5:0] round_to_6(input logic [7:0] c);
        logic [8:0] sum;
        sum = {1'b0, c} + 9'd2;
        if (sum[8]) begin
            return 6'd63;
        end else begin
            return sum[7:2];
        end
    endfunction

endpackage

// File: rtl/rgb888_to_rgb565.sv
// RGB888 to RGB565 packing. Combinational truncation by default; with
// SRAM_FRAME_WRITER_ROUND_EN defined, round-to-nearest into a register loaded on accept.
module rgb888_to_rgb565
    import vga_fb_pkg::*;
(
`ifdef SRAM_FRAME_WRITER_ROUND_EN
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
`endif
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic [15:0] rgb565
);

    logic [15:0] packed_s;

`ifdef SRAM_FRAME_WRITER_ROUND_EN
    // Rounded channel packing
    always_comb begin
        packed_s = 16'd0;
        packed_s[RGB565_R_MSB:RGB565_R_LSB] = round_to_5(r);
        packed_s[RGB565_G_MSB:RGB565_G_LSB] = round_to_6(g);
        packed_s[RGB565_B_MSB:RGB565_B_LSB] = round_to_5(b);
    end

    // Pipeline register holding the converted pixel until SETUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb565 <= 16'd0;
        end else if (load) begin
            rgb565 <= packed_s;
        end else begin
            rgb565 <= rgb565;
        end
    end
`else
    logic unused_lsbs_s;
    assign unused_lsbs_s = ^{r[2:0], g[1:0], b[2:0]};

    // Truncating channel packing
    always_comb begin
        packed_s = 16'd0;
        packed_s[RGB565_R_MSB:RGB565_R_LSB] = r[7:3];
        packed_s[RGB565_G_MSB:RGB565_G_LSB] = g[7:2];
        packed_s[RGB565_B_MSB:RGB565_B_LSB] = b[7:3];
    end

    assign rgb565 = packed_s;
`endif

endmodule

// File: rtl/sram_frame_writer.sv
// Raster RGB888 stream to async SRAM frame buffer writer (setup / write-pulse / hold).
// Optional rounding conversion stage: define SRAM_FRAME_WRITER_ROUND_EN.
module sram_frame_writer
    import vga_fb_pkg::*;
#(
    parameter int H_DISPLAY = DEFAULT_H_DISPLAY,
    parameter int V_DISPLAY = DEFAULT_V_DISPLAY,
    parameter int ADDR_W    = 20,
    parameter int WE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              pix_sof,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    output logic [ADDR_W-1:0] sram_address,
    output logic [15:0]       sram_wdata,
    output logic              sram_we_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              frame_done,
    output logic              busy
);

    localparam int XW    = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1;
    localparam int YW    = (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1;
    localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    localparam logic [XW-1:0]    X_LAST     = XW'(H_DISPLAY - 1);
    localparam logic [YW-1:0]    Y_LAST     = YW'(V_DISPLAY - 1);
    localparam logic [CNT_W-1:0] LAST_PULSE = CNT_W'(WE_CYCLES - 1);

    if (longint'(H_DISPLAY) * longint'(V_DISPLAY) > (longint'(1) << ADDR_W)) begin : g_bad_size
        $error("sram_frame_writer: H_DISPLAY*V_DISPLAY exceeds 2**ADDR_W");
    end
    if (WE_CYCLES < 1) begin : g_bad_we
        $error("sram_frame_writer: WE_CYCLES must be at least 1");
    end

    fb_wr_state_t      state_r;
    fb_wr_state_t      state_nxt_s;
    logic [CNT_W-1:0]  we_cnt_r;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [15:0]       rgb565_s;
    logic              accept_s;
    logic              load_s;
    logic              x_last_s;
    logic              y_last_s;

    assign accept_s   = pix_valid && pix_ready;
    assign load_s     = (state_nxt_s == SETUP) && (state_r != SETUP);
    assign cur_addr_s = (accept_s && pix_sof) ? '0 : addr_r;
    assign x_last_s   = (x_r == X_LAST);
    assign y_last_s   = (y_r == Y_LAST);
    assign sram_oe_n  = 1'b1;

`ifdef SRAM_FRAME_WRITER_ROUND_EN
    rgb888_to_rgb565 u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept_s),
        .r      (pix_r),
        .g      (pix_g),
        .b      (pix_b),
        .rgb565 (rgb565_s)
    );
`else
    rgb888_to_rgb565 u_conv (
        .r      (pix_r),
        .g      (pix_g),
        .b      (pix_b),
        .rgb565 (rgb565_s)
    );
`endif

    // Next-state logic for the write cycle sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef SRAM_FRAME_WRITER_ROUND_EN
                    state_nxt_s = CONV;
`else
                    state_nxt_s = SETUP;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONV:  state_nxt_s = SETUP;
            SETUP: state_nxt_s = WRITE;
            WRITE: begin
                if (we_cnt_r == LAST_PULSE) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            HOLD:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and write-pulse length counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            we_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == WRITE) begin
                we_cnt_r <= we_cnt_r + CNT_W'(1);
            end else begin
                we_cnt_r <= '0;
            end
        end
    end

    // Raster position and linear address; sof rewinds before the pixel's address is used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= '0;
            y_r    <= '0;
            addr_r <= '0;
        end else if (accept_s && pix_sof) begin
            x_r    <= '0;
            y_r    <= '0;
            addr_r <= '0;
        end else if (state_r == HOLD) begin
            if (x_last_s) begin
                x_r <= '0;
                if (y_last_s) begin
                    y_r    <= '0;
                    addr_r <= '0;
                end else begin
                    y_r    <= y_r + YW'(1);
                    addr_r <= addr_r + ADDR_W'(1);
                end
            end else begin
                x_r    <= x_r + XW'(1);
                addr_r <= addr_r + ADDR_W'(1);
            end
        end else begin
            x_r    <= x_r;
            y_r    <= y_r;
            addr_r <= addr_r;
        end
    end

    // SRAM strobes, address/data latches and status outputs, all registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_address <= '0;
            sram_wdata   <= 16'd0;
            sram_we_n    <= 1'b1;
            sram_ce_n    <= 1'b1;
            pix_ready    <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (load_s) begin
                sram_address <= cur_addr_s;
                sram_wdata   <= rgb565_s;
                sram_ce_n    <= 1'b0;
            end else if (state_r == HOLD) begin
                sram_ce_n    <= 1'b1;
            end else begin
                sram_ce_n    <= sram_ce_n;
            end
            sram_we_n  <= (state_nxt_s != WRITE);
            pix_ready  <= (state_nxt_s == IDLE);
            busy       <= (state_nxt_s != IDLE);
            frame_done <= (state_r == HOLD) && x_last_s && y_last_s;
        end
    end

endmodule

// File: tb/tb_sram_frame_writer.sv
// Self-checking bench for sram_frame_writer on a 4x3 raster: directed steps plus
// randomized pixels, checked against a linear-position reference model and an SRAM bus monitor.
module tb_sram_frame_writer;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int WEC = 2;
    localparam int AW  = 20;
`ifdef SRAM_FRAME_WRITER_ROUND_EN
    localparam bit ROUND  = 1'b1;
    localparam int PERIOD = WEC + 4;
`else
    localparam bit ROUND  = 1'b0;
    localparam int PERIOD = WEC + 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_sof;
    logic [7:0]    pix_r;
    logic [7:0]    pix_g;
    logic [7:0]    pix_b;
    logic [AW-1:0] sram_address;
    logic [15:0]   sram_wdata;
    logic          sram_we_n;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          frame_done;
    logic          busy;

    always #5 clk = ~clk;

    sram_frame_writer #(
        .H_DISPLAY (H),
        .V_DISPLAY (V),
        .ADDR_W    (AW),
        .WE_CYCLES (WEC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_sof      (pix_sof),
        .pix_r        (pix_r),
        .pix_g        (pix_g),
        .pix_b        (pix_b),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_we_n    (sram_we_n),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    int checks = 0;
    int passes = 0;
    int exp_addr[$];
    int exp_data[$];
    int pos, exp_frames, seen_frames, cyc, last_acc_cyc, last_wr_addr, last_wr_data, low_cnt;
    bit gap, in_pulse, last_acc, prev_fd, prev_we, prev_ce;
    logic [AW-1:0] prev_addr, pulse_addr;
    logic [15:0]   prev_data, pulse_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int conv(input int r, input int g, input int b);
        int rr, gg, bb;
        if (ROUND) begin
            rr = (r + 4) / 8;
            gg = (g + 2) / 4;
            bb = (b + 4) / 8;
            if (rr > 31) rr = 31;
            if (gg > 63) gg = 63;
            if (bb > 31) bb = 31;
        end else begin
            rr = r / 8;
            gg = g / 4;
            bb = b / 8;
        end
        return rr * 2048 + gg * 32 + bb;
    endfunction

    // Watches the SRAM bus once per cycle (at the falling edge) and retires completed writes.
    task automatic monitor();
        if (frame_done) begin
            seen_frames++;
            chk("frame_done_after_last", last_wr_addr, H * V - 1);
            chk("frame_done_one_cycle", prev_fd, 0);
        end
        chk("busy_vs_ready", busy, !pix_ready);
        chk("oe_high", sram_oe_n, 1);
        if (!sram_we_n) begin
            chk("ce_during_write", sram_ce_n, 0);
            if (!in_pulse) begin
                in_pulse   = 1;
                low_cnt    = 1;
                pulse_addr = sram_address;
                pulse_data = sram_wdata;
                chk("setup_we_high", prev_we, 1);
                chk("setup_ce_low", prev_ce, 0);
                chk("setup_addr", prev_addr, sram_address);
                chk("setup_data", prev_data, sram_wdata);
            end else begin
                low_cnt++;
                chk("addr_stable", sram_address, pulse_addr);
                chk("data_stable", sram_wdata, pulse_data);
            end
        end else if (in_pulse) begin
            in_pulse = 0;
            chk("we_low_cycles", low_cnt, WEC);
            chk("hold_ce_low", sram_ce_n, 0);
            chk("hold_addr", sram_address, pulse_addr);
            chk("hold_data", sram_wdata, pulse_data);
            chk("write_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) begin
                chk("wr_addr", pulse_addr, exp_addr.pop_front());
                chk("wr_data", pulse_data, exp_data.pop_front());
            end
            last_wr_addr = pulse_addr;
            last_wr_data = pulse_data;
        end
        prev_fd   = frame_done;
        prev_we   = sram_we_n;
        prev_ce   = sram_ce_n;
        prev_addr = sram_address;
        prev_data = sram_wdata;
    endtask

    // One clock: note an accept (model update) at the coming edge, then observe at the falling edge.
    task automatic cycle();
        last_acc = pix_valid && pix_ready && rst_n;
        if (!pix_valid) gap = 1;
        if (last_acc) begin
            if (pix_sof) pos = 0;
            exp_addr.push_back(pos);
            exp_data.push_back(conv(pix_r, pix_g, pix_b));
            pos++;
            if (pos == H * V) begin
                pos = 0;
                exp_frames++;
            end
            if (!gap && last_acc_cyc >= 0) chk("pixel_period", cyc - last_acc_cyc, PERIOD);
            gap = 0;
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rst_n) monitor();
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic sof, input bit keep_valid);
        int n;
        pix_valid = 1'b1;
        pix_r = r;
        pix_g = g;
        pix_b = b;
        pix_sof = sof;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 40);
        chk("accept_timeout", last_acc, 1);
        pix_sof = 1'b0;
        if (!keep_valid) pix_valid = 1'b0;
    endtask

    task automatic send_rand(input logic sof, input bit keep_valid);
        send(8'($urandom), 8'($urandom), 8'($urandom), sof, keep_valid);
    endtask

    // Idle cycles with random sof/data while pix_valid is low
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b0;
            pix_sof = 1'($urandom_range(0, 1));
            pix_r = 8'($urandom);
            cycle();
        end
        pix_sof = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        while ((!pix_ready || in_pulse || exp_addr.size() != 0) && n < 50) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        chk("drain_queue_empty", exp_addr.size(), 0);
    endtask

    task automatic clear_prev();
        prev_we = 1'b1;
        prev_ce = 1'b1;
        prev_fd = 1'b0;
        prev_addr = '0;
        prev_data = 16'd0;
        in_pulse = 0;
        last_acc_cyc = -1;
        gap = 1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        pix_r = 8'd0;
        pix_g = 8'd0;
        pix_b = 8'd0;
        pos = 0;
        exp_frames = 0;
        seen_frames = 0;
        cyc = 0;
        last_wr_addr = -1;
        last_wr_data = -1;
        low_cnt = 0;
        clear_prev();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_addr", sram_address, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_ready", pix_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        cycle();
        chk("ready_after_reset", pix_ready, 1);

        // Single pixel with sof; rounding leaves it unchanged (130>>2 = 32, 20>>3 = 2)
        send(8'hFF, 8'h80, 8'h10, 1'b1, 1'b0);
        n = 0;
        while (!pix_ready && n < 20) begin
            cycle();
            n++;
        end
        chk("ready_return_cycles", n, PERIOD - 1);
        drain();
        chk("first_addr", last_wr_addr, 0);
        chk("first_data", last_wr_data, 16'hFC02);

        // Rest of the frame with pix_valid held; frame_done once, then wrap to 0
        for (int i = 1; i < H * V; i++) send_rand(1'b0, 1'b1);
        drain();
        chk("frame_last_addr", last_wr_addr, H * V - 1);
        chk("frame_done_count", seen_frames, 1);
        send_rand(1'b0, 1'b0);
        drain();
        chk("wrap_addr", last_wr_addr, 0);

        // Resync: sof on the 6th pixel of a frame
        send_rand(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_rand(1'b0, 1'b1);
        send_rand(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send_rand(1'b0, 1'b1);
        drain();
        chk("resync_last_addr", last_wr_addr, 5);
        chk("resync_no_frame_done", seen_frames, 1);

        // Reset dropped while sram_we_n is low
        send_rand(1'b0, 1'b0);
        n = 0;
        while (sram_we_n && n < 20) begin
            cycle();
            n++;
        end
        chk("reached_write", sram_we_n, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_we_n", sram_we_n, 1);
        chk("async_rst_ce_n", sram_ce_n, 1);
        chk("async_rst_ready", pix_ready, 0);
        chk("async_rst_busy", busy, 0);
        exp_addr.delete();
        exp_data.delete();
        pos = 0;
        clear_prev();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();
        send_rand(1'b0, 1'b0);
        drain();
        chk("post_reset_addr", last_wr_addr, 0);

        // Randomized stream with gaps, held valid and occasional sof
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_rand(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end
        drain();
        chk("random_frame_count", seen_frames, exp_frames);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
